mm_job_scheduler: RTL and testbench
===================================

Name: mm_job_scheduler

Overview:
- Queues Montgomery-multiplication jobs and runs them one at a time on a single MM core, sharing one BRAM master port between jobs.
- Each job carries a BRAM word base address. The block relocates the core's word addresses by that base, pulses the core start, waits for done, and returns a tagged completion.
- It sits between the processor-facing command/response interface and the MM core plus BRAM controller. A watchdog aborts a hung job.

Parameters:
- ADDR_W, 15, width of BRAM word addresses (base and core address).
- TAG_W, 4, width of the job tag.
- FIFO_DEPTH, 4, command FIFO entries; must be a power of two, ≥2.
- TIMEOUT, 4096, maximum RUN cycles before abort; 0 disables the watchdog.

Ports:
- clock_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  FIFO not full.
- cmd_base_i  in  ADDR_W  job base word address.
- cmd_tag_i  in  TAG_W  job tag.
- rsp_valid_o  out  1  completion available.
- rsp_ready_i  in  1  completion consumed.
- rsp_tag_o  out  TAG_W  tag of the completed job.
- rsp_err_o  out  1  1 = job aborted by the watchdog.
- busy_o  out  1  state ≠ IDLE, or FIFO non-empty.
- mm_start_o  out  1  one-cycle start pulse to the core.
- mm_abort_o  out  1  one-cycle pulse, ORed into the core reset.
- mm_done_i  in  1  core done.
- mm_addr_i  in  ADDR_W  core word address.
- mm_en_i  in  1  core BRAM enable.
- mm_we_i  in  1  core write enable.
- mm_din_i  in  17  core write data.
- BRAM_addr_o  out  32  byte address.
- BRAM_en_o  out  1  BRAM enable.
- BRAM_we_o  out  4  byte write enables.
- BRAM_din_o  out  32  BRAM write data.

Behaviour:

Reset
- On reset_i high, immediately: FIFO emptied, state IDLE, watchdog counter 0.
- All outputs 0, except cmd_ready_o = 1.
- Reset mid-job drops the job and every queued command; no response is produced.

Command FIFO
- Push when cmd_valid_i && cmd_ready_o.
- cmd_ready_o = !full, registered and combinational on FIFO count only.
- A push while full is ignored.
- Push and pop in the same cycle are both legal; count is unchanged.
- No bypass: a command pushed into an empty FIFO is visible to the FSM one cycle later.
- Pointers wrap modulo FIFO_DEPTH.

FSM: IDLE, START, RUN, RESP
- IDLE: if FIFO non-empty, pop the head, latch base/tag into registers, go to START.
- START: mm_start_o = 1 for exactly this one cycle; clear the watchdog counter; go to RUN.
- RUN: watchdog counter increments each cycle.
  - If mm_done_i = 1: rsp_err = 0, go to RESP.
  - Else if TIMEOUT ≠ 0 and counter = TIMEOUT−1: mm_abort_o = 1 for one cycle, rsp_err = 1, go to RESP.
  - If done and timeout coincide, done wins (err = 0, no abort).
- RESP: rsp_valid_o = 1, holding rsp_tag_o/rsp_err_o stable. On rsp_ready_i, go to IDLE.
- mm_done_i is ignored outside RUN.

Latency
- Command accepted at edge k into an idle, empty scheduler:
  - edge k+1 → START
  - mm_start_o high between edges k+1 and k+2
  - edge k+2 → RUN
- Back-to-back jobs: minimum 2 cycles from the RESP handshake edge to the next mm_start_o (IDLE, then START).

BRAM port
- Combinational from core inputs and latched base.
- Active only in RUN.
  - BRAM_en_o = mm_en_i.
  - BRAM_we_o = {4{mm_we_i}}.
  - BRAM_addr_o = zero-extend((base + mm_addr_i) mod 2^ADDR_W) << 2, so bits [1:0] = 0.
  - BRAM_din_o = {15'b0, mm_din_i}.
- In all other states, BRAM_en_o/BRAM_we_o = 0, BRAM_addr_o = 0, BRAM_din_o = 0.

Test Plan:
- Reset then single job: push base=0x100, tag=3. Require mm_start_o 2 cycles after accept. Drive mm_addr_i=5, mm_en_i=1 → BRAM_addr_o=0x414. Pulse done → rsp_valid_o with tag 3, err 0.
- FIFO full: hold the core busy and push 5 commands. Require cmd_ready_o=0 after the 4th accept into the FIFO while job 1 runs. Completions must emerge in tag order.
- Wrap-around: base=0x7FFF, mm_addr_i=2 (ADDR_W=15) → BRAM_addr_o=0x4. Write with mm_we_i=1, mm_din_i=0x1FFFF → BRAM_we_o=0xF, BRAM_din_o=0x0001FFFF.
- Watchdog: TIMEOUT=16 with no done. Require mm_abort_o single pulse on RUN cycle 16, then rsp_err_o=1. A done arriving on that same cycle instead gives err=0 and no abort.
- Response backpressure: hold rsp_ready_i=0 for 10 cycles. RESP persists and tag stays stable. No second mm_start_o even if the FIFO is non-empty.
- Async reset mid-RUN with 2 queued jobs: all outputs drop in the same cycle and cmd_ready_o=1. No rsp_valid_o and no mm_start_o afterward until a new push.

Source files
------------

// File: rtl/mm_job_scheduler.sv
// Montgomery-multiplication job scheduler: queues jobs, runs them one at a
// time on a single MM core, relocates the core's BRAM word addresses by the
// job base, and returns tagged completions. A watchdog aborts hung jobs.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a queued job; pops FIFO head and latches base/tag
// S_START | one-cycle core start pulse, watchdog cleared
// S_RUN   | core owns the BRAM port; waiting for done or watchdog expiry
// S_RESP  | completion presented until the consumer accepts it
module mm_job_scheduler #(
    parameter int ADDR_W     = 15,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_base_i,
    input  logic [TAG_W-1:0]  cmd_tag_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [TAG_W-1:0]  rsp_tag_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              mm_start_o,
    output logic              mm_abort_o,
    input  logic              mm_done_i,
    input  logic [ADDR_W-1:0] mm_addr_i,
    input  logic              mm_en_i,
    input  logic              mm_we_i,
    input  logic [16:0]       mm_din_i,
    output logic [31:0]       BRAM_addr_o,
    output logic              BRAM_en_o,
    output logic [3:0]        BRAM_we_o,
    output logic [31:0]       BRAM_din_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   wd_q, wd_d;
    logic [ADDR_W-1:0]  fifo_base_q [FIFO_DEPTH];
    logic [TAG_W-1:0]   fifo_tag_q  [FIFO_DEPTH];

    logic               fifo_full, fifo_empty, push, pop;
    logic [ADDR_W-1:0]  bram_word;

    assign fifo_full   = (count_q == FULL_CNT);
    assign fifo_empty  = (count_q == '0);
    assign cmd_ready_o = !fifo_full;
    assign push        = cmd_valid_i && !fifo_full;
    assign pop         = (state_q == S_IDLE) && !fifo_empty;

    // FIFO pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
        else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
    end

    // FIFO storage; a full FIFO never writes, so the head is never overwritten
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_base_q[i] <= '0;
                fifo_tag_q[i]  <= '0;
            end
        end else if (push) begin
            fifo_base_q[wr_ptr_q] <= cmd_base_i;
            fifo_tag_q[wr_ptr_q]  <= cmd_tag_i;
        end
    end

    // Next-state, job latch, watchdog and core control pulses
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        tag_d      = tag_q;
        err_d      = err_q;
        wd_d       = wd_q;
        mm_start_o = 1'b0;
        mm_abort_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    base_d  = fifo_base_q[rd_ptr_q];
                    tag_d   = fifo_tag_q[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                mm_start_o = 1'b1;
                wd_d       = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                wd_d = wd_q + CNT_W'(1);
                // done takes priority over a coincident watchdog expiry
                if (mm_done_i) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
                    mm_abort_o = 1'b1;
                    err_d      = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            base_q   <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            base_q   <= base_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_tag_o   = rsp_valid_o ? tag_q : '0;
    assign rsp_err_o   = rsp_valid_o && err_q;
    assign busy_o      = (state_q != S_IDLE) || !fifo_empty;
    assign bram_word   = base_q + mm_addr_i;

    // BRAM master port belongs to the core only while a job is running
    always_comb begin
        BRAM_addr_o = '0;
        BRAM_en_o   = 1'b0;
        BRAM_we_o   = '0;
        BRAM_din_o  = '0;
        if (state_q == S_RUN) begin
            BRAM_addr_o = 32'(bram_word) << 2;
            BRAM_en_o   = mm_en_i;
            BRAM_we_o   = {4{mm_we_i}};
            BRAM_din_o  = {15'b0, mm_din_i};
        end
    end

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Directed bench for mm_job_scheduler with a response scoreboard.
module tb_mm_job_scheduler;

    localparam int ADDR_W = 15;
    localparam int TAG_W  = 4;

    logic              clock_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [ADDR_W-1:0] cmd_base_i = '0;
    logic [TAG_W-1:0]  cmd_tag_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b1;
    logic [TAG_W-1:0]  rsp_tag_o;
    logic              rsp_err_o;
    logic              busy_o;
    logic              mm_start_o;
    logic              mm_abort_o;
    logic              mm_done_i = 1'b0;
    logic [ADDR_W-1:0] mm_addr_i = '0;
    logic              mm_en_i = 1'b0;
    logic              mm_we_i = 1'b0;
    logic [16:0]       mm_din_i = '0;
    logic [31:0]       BRAM_addr_o;
    logic              BRAM_en_o;
    logic [3:0]        BRAM_we_o;
    logic [31:0]       BRAM_din_o;

    int checks = 0;
    int failures = 0;
    logic [TAG_W:0] exp_q [$];
    logic [TAG_W:0] mon_e;

    mm_job_scheduler #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_base_i(cmd_base_i), .cmd_tag_i(cmd_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .mm_start_o(mm_start_o), .mm_abort_o(mm_abort_o), .mm_done_i(mm_done_i),
        .mm_addr_i(mm_addr_i), .mm_en_i(mm_en_i), .mm_we_i(mm_we_i), .mm_din_i(mm_din_i),
        .BRAM_addr_o(BRAM_addr_o), .BRAM_en_o(BRAM_en_o),
        .BRAM_we_o(BRAM_we_o), .BRAM_din_o(BRAM_din_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic expect_rsp(input logic [TAG_W-1:0] t, input logic e);
        exp_q.push_back({t, e});
    endtask

    task automatic push(input logic [ADDR_W-1:0] b, input logic [TAG_W-1:0] t);
        bit acc = 0;
        cmd_valid_i = 1'b1;
        cmd_base_i  = b;
        cmd_tag_i   = t;
        for (int i = 0; i < 60 && !acc; i++) begin
            acc = cmd_ready_o;
            step();
        end
        cmd_valid_i = 1'b0;
        check($sformatf("push_accept_tag%0d", t), 32'(acc), 32'd1);
    endtask

    // Leaves the bench in the START cycle of the next job.
    task automatic wait_start();
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (mm_start_o) seen = 1;
            else step();
        end
        check("start_seen", 32'(seen), 32'd1);
    endtask

    // From a START cycle: done is raised on RUN cycle n; ends in RESP.
    task automatic finish_job(input int n);
        step();
        repeat (n - 1) step();
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && rsp_valid_o; i++) step();
        check("rsp_drained", 32'(rsp_valid_o), 32'd0);
    endtask

    // Scoreboard monitor: compares every completion handshake against the queue
    always @(negedge clock_i) begin
        if (!reset_i && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual_tag=%0d actual_err=%0d required=none", rsp_tag_o, rsp_err_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_tag", 32'(rsp_tag_o), 32'(mon_e[TAG_W:1]));
                check("rsp_err", 32'(rsp_err_o), 32'(mon_e[0]));
            end
        end
    end

    initial begin
        bit saw_start, saw_valid;

        // reset state
        #3;
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_start", 32'(mm_start_o), 32'd0);
        check("rst_bram_en", 32'(BRAM_en_o), 32'd0);
        check("rst_bram_addr", BRAM_addr_o, 32'd0);
        step(); step();
        reset_i = 1'b0;
        step();

        // single job: start latency and relocation
        expect_rsp(4'd3, 1'b0);
        push(15'h100, 4'd3);
        check("lat_k_start", 32'(mm_start_o), 32'd0);
        check("lat_k_busy", 32'(busy_o), 32'd1);
        step();
        check("lat_k1_start", 32'(mm_start_o), 32'd1);
        step();
        check("lat_k2_start", 32'(mm_start_o), 32'd0);
        mm_addr_i = 15'd5;
        mm_en_i   = 1'b1;
        #1;
        check("reloc_addr", BRAM_addr_o, 32'h414);
        check("reloc_en", 32'(BRAM_en_o), 32'd1);
        check("reloc_we", 32'(BRAM_we_o), 32'h0);
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
        mm_en_i   = 1'b0;
        check("single_rsp_valid", 32'(rsp_valid_o), 32'd1);
        step();
        check("single_idle_valid", 32'(rsp_valid_o), 32'd0);
        check("single_idle_busy", 32'(busy_o), 32'd0);

        // FIFO full while job 1 runs, completions in order
        for (int t = 1; t <= 5; t++) expect_rsp(TAG_W'(t), 1'b0);
        for (int t = 1; t <= 5; t++) push(ADDR_W'(t * 16), TAG_W'(t));
        check("full_ready", 32'(cmd_ready_o), 32'd0);
        cmd_valid_i = 1'b1;
        cmd_tag_i   = 4'd6;
        for (int i = 0; i < 3; i++) begin
            check("full_ready_hold", 32'(cmd_ready_o), 32'd0);
            step();
        end
        cmd_valid_i = 1'b0;
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
        for (int j = 2; j <= 5; j++) begin
            wait_start();
            finish_job(3);
        end
        wait_idle();
        check("full_drain_busy", 32'(busy_o), 32'd0);
        check("full_queue_empty", 32'(exp_q.size()), 32'd0);

        // address wrap-around and write path
        expect_rsp(4'd7, 1'b0);
        push(15'h7FFF, 4'd7);
        wait_start();
        step();
        mm_addr_i = 15'd2;
        mm_en_i   = 1'b1;
        mm_we_i   = 1'b1;
        mm_din_i  = 17'h1FFFF;
        #1;
        check("wrap_addr", BRAM_addr_o, 32'h4);
        check("wrap_we", 32'(BRAM_we_o), 32'hF);
        check("wrap_din", BRAM_din_o, 32'h0001FFFF);
        check("wrap_en", 32'(BRAM_en_o), 32'd1);
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
        check("resp_bram_en", 32'(BRAM_en_o), 32'd0);
        check("resp_bram_we", 32'(BRAM_we_o), 32'd0);
        check("resp_bram_addr", BRAM_addr_o, 32'd0);
        check("resp_bram_din", BRAM_din_o, 32'd0);
        mm_en_i = 1'b0; mm_we_i = 1'b0; mm_din_i = '0; mm_addr_i = '0;
        wait_idle();

        // watchdog abort on RUN cycle 16
        expect_rsp(4'd9, 1'b1);
        push(15'h200, 4'd9);
        wait_start();
        step();
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("wd_abort_c%0d", c), 32'(mm_abort_o), (c == 16) ? 32'd1 : 32'd0);
            step();
        end
        check("wd_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("wd_rsp_err", 32'(rsp_err_o), 32'd1);
        check("wd_abort_once", 32'(mm_abort_o), 32'd0);
        wait_idle();

        // done coinciding with watchdog expiry wins
        expect_rsp(4'd10, 1'b0);
        push(15'h300, 4'd10);
        wait_start();
        step();
        repeat (15) step();
        mm_done_i = 1'b1;
        #1;
        check("coinc_abort", 32'(mm_abort_o), 32'd0);
        step();
        mm_done_i = 1'b0;
        check("coinc_err", 32'(rsp_err_o), 32'd0);
        wait_idle();

        // response backpressure and back-to-back latency
        rsp_ready_i = 1'b0;
        expect_rsp(4'd11, 1'b0);
        expect_rsp(4'd12, 1'b0);
        push(15'h400, 4'd11);
        push(15'h500, 4'd12);
        wait_start();
        finish_job(2);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(rsp_valid_o), 32'd1);
            check("bp_tag", 32'(rsp_tag_o), 32'd11);
            check("bp_no_start", 32'(mm_start_o), 32'd0);
            step();
        end
        rsp_ready_i = 1'b1;
        step();
        check("b2b_idle_start", 32'(mm_start_o), 32'd0);
        step();
        check("b2b_start", 32'(mm_start_o), 32'd1);
        finish_job(1);
        wait_idle();

        // async reset mid-RUN with two queued jobs
        push(15'h600, 4'd13);
        push(15'h610, 4'd14);
        push(15'h620, 4'd15);
        mm_addr_i = 15'd1;
        mm_en_i   = 1'b1;
        #1;
        check("prereset_run_en", 32'(BRAM_en_o), 32'd1);
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_bram_en", 32'(BRAM_en_o), 32'd0);
        check("arst_bram_addr", BRAM_addr_o, 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("arst_start", 32'(mm_start_o), 32'd0);
        step(); step();
        reset_i = 1'b0;
        mm_en_i = 1'b0;
        saw_start = 0;
        saw_valid = 0;
        for (int i = 0; i < 20; i++) begin
            saw_start |= mm_start_o;
            saw_valid |= rsp_valid_o;
            step();
        end
        check("post_rst_no_start", 32'(saw_start), 32'd0);
        check("post_rst_no_rsp", 32'(saw_valid), 32'd0);

        // scheduler still usable after reset
        expect_rsp(4'd2, 1'b0);
        push(15'h010, 4'd2);
        wait_start();
        finish_job(1);
        wait_idle();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
